// File: rtl/if_fetch_queue.sv
// Instruction fetch queue: turns pc_in into imem requests, tags in-order responses with their PC, queues them for decode.
// Latency: response accepted at edge N appears on dec_valid after edge N (1 cycle, no bypass); request path is combinational.
// Backpressure: credit-based; requests stop once queued + outstanding reaches DEPTH, so responses are always accepted.
//
// Ports:
//   clk, rst                              clock, asynchronous active-high reset
//   pc_in, redirect, pc_stall             PC stage interface (pc_stall = request did not fire)
//   imem_req_valid/ready/addr             instruction memory request (word aligned)
//   imem_resp_valid/data                  in-order memory response, always accepted
//   dec_valid/ready, dec_instr/pc/exc     head of queue to decode
// Build option: FETCH_MISALIGN_CHECK_EN turns a misaligned pc_in into a synthetic
// exception entry (NOP, exc=1) and stops fetching until the next redirect.
module if_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc_in,
  input  logic          redirect,
  output logic          pc_stall,
  output logic          imem_req_valid,
  input  logic          imem_req_ready,
  output logic [AW-1:0] imem_req_addr,
  input  logic          imem_resp_valid,
  input  logic [31:0]   imem_resp_data,
  output logic          dec_valid,
  input  logic          dec_ready,
  output logic [31:0]   dec_instr,
  output logic [AW-1:0] dec_pc,
  output logic          dec_exc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);

  // Decode queue storage
  logic [AW-1:0] q_pc_q    [DEPTH];
  logic [AW-1:0] q_pc_d    [DEPTH];
  logic [31:0]   q_instr_q [DEPTH];
  logic [31:0]   q_instr_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Requests in flight and how many of them belong to a flushed path
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;

  // PCs of outstanding requests, consumed in response order
  logic [AW-1:0] rpc_q [DEPTH];
  logic [AW-1:0] rpc_d [DEPTH];
  logic [PW-1:0] rpc_rd_q, rpc_rd_d, rpc_wr_q, rpc_wr_d;

  logic          credit_ok;
  logic          req_fire;
  logic          resp_take;
  logic          resp_drop;
  logic          resp_push;
  logic          push;
  logic          pop;
  logic [AW-1:0] push_pc;
  logic [31:0]   push_instr;

`ifdef FETCH_MISALIGN_CHECK_EN
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic          q_exc_q [DEPTH];
  logic          q_exc_d [DEPTH];
  logic          stopped_q, stopped_d;
  logic          synth_pending_q, synth_pending_d;
  logic [AW-1:0] synth_pc_q, synth_pc_d;
  logic          misalign;
  logic          fetch_ok;
  logic          misalign_hit;
  logic          synth_push;
  logic          push_exc;
`endif

  assign credit_ok = ({1'b0, count_q} + {1'b0, outstanding_q}) < DEPTH_W;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign       = pc_in[1:0] != 2'b00;
  assign fetch_ok       = !rst && !redirect && credit_ok && !stopped_q;
  assign imem_req_valid = fetch_ok && !misalign;
  assign misalign_hit   = fetch_ok && misalign;
  // Synthetic entry waits until every older response has landed so it stays in program order.
  assign synth_push     = synth_pending_q && (outstanding_q == '0) && !redirect;
`else
  assign imem_req_valid = !rst && !redirect && credit_ok;
`endif

  assign imem_req_addr = {pc_in[AW-1:2], 2'b00};
  assign req_fire      = imem_req_valid && imem_req_ready;
  assign pc_stall      = !req_fire;

  // A response with nothing outstanding cannot be tagged; it is ignored.
  assign resp_take = imem_resp_valid && (outstanding_q != '0);
  assign resp_drop = resp_take && (redirect || (discard_q != '0));
  assign resp_push = resp_take && !resp_drop;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign push = resp_push || synth_push;
`else
  assign push = resp_push;
`endif

  assign dec_valid = count_q != '0;
  assign pop       = dec_valid && dec_ready;
  assign dec_instr = q_instr_q[rd_ptr_q];
  assign dec_pc    = q_pc_q[rd_ptr_q];
`ifdef FETCH_MISALIGN_CHECK_EN
  assign dec_exc   = q_exc_q[rd_ptr_q];
`else
  assign dec_exc   = 1'b0;
`endif

  // Push data: a memory response, or the synthetic misalign entry (never both in one cycle).
  always_comb begin
    push_pc    = rpc_q[rpc_rd_q];
    push_instr = imem_resp_data;
`ifdef FETCH_MISALIGN_CHECK_EN
    push_exc   = 1'b0;
    if (synth_push) begin
      push_pc    = synth_pc_q;
      push_instr = NOP;
      push_exc   = 1'b1;
    end
`endif
  end

  always_comb begin
    q_pc_d        = q_pc_q;
    q_instr_d     = q_instr_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    rpc_d         = rpc_q;
    rpc_rd_d      = rpc_rd_q;
    rpc_wr_d      = rpc_wr_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    q_exc_d         = q_exc_q;
    stopped_d       = stopped_q;
    synth_pending_d = synth_pending_q;
    synth_pc_d      = synth_pc_q;
`endif

    if (push) begin
      q_pc_d[wr_ptr_q]    = push_pc;
      q_instr_d[wr_ptr_q] = push_instr;
`ifdef FETCH_MISALIGN_CHECK_EN
      q_exc_d[wr_ptr_q]   = push_exc;
`endif
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (req_fire) begin
      rpc_d[rpc_wr_q] = pc_in;
      rpc_wr_d        = rpc_wr_q + PTR_ONE;
    end
    // Every response, kept or dropped, retires the oldest request PC.
    if (resp_take) begin
      rpc_rd_d = rpc_rd_q + PTR_ONE;
    end
    unique case ({req_fire, resp_take})
      2'b10:   outstanding_d = outstanding_q + CNT_ONE;
      2'b01:   outstanding_d = outstanding_q - CNT_ONE;
      default: outstanding_d = outstanding_q;
    endcase

    if (redirect) begin
      // No request fires on a redirect, so what is still in flight after this edge is all stale.
      discard_d = resp_take ? (outstanding_q - CNT_ONE) : outstanding_q;
      count_d   = '0;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
    end else if (resp_drop) begin
      discard_d = discard_q - CNT_ONE;
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    if (redirect) begin
      stopped_d       = 1'b0;
      synth_pending_d = 1'b0;
    end else if (misalign_hit) begin
      stopped_d       = 1'b1;
      synth_pending_d = 1'b1;
      synth_pc_d      = pc_in;
    end else if (synth_push) begin
      synth_pending_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_pc_q[i]    <= '0;
        q_instr_q[i] <= '0;
        rpc_q[i]     <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
        q_exc_q[i]   <= 1'b0;
`endif
      end
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      rpc_rd_q      <= '0;
      rpc_wr_q      <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      stopped_q       <= 1'b0;
      synth_pending_q <= 1'b0;
      synth_pc_q      <= '0;
`endif
    end else begin
      q_pc_q        <= q_pc_d;
      q_instr_q     <= q_instr_d;
      rpc_q         <= rpc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      rpc_rd_q      <= rpc_rd_d;
      rpc_wr_q      <= rpc_wr_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      q_exc_q         <= q_exc_d;
      stopped_q       <= stopped_d;
      synth_pending_q <= synth_pending_d;
      synth_pc_q      <= synth_pc_d;
`endif
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: PC-stage model, in-order memory model with configurable latency,
// and a scoreboard of expected decode entries pushed when a response is driven.
module tb_if_fetch_queue;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic        redirect;
  logic        pc_stall;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_exc;

  if_fetch_queue #(.DEPTH(4), .AW(32)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .redirect(redirect), .pc_stall(pc_stall),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc),
    .dec_exc(dec_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } ent_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] pc;
    int          due;
    bit          stale;
  } mreq_t;

  mreq_t       mq[$];
  ent_t        exq[$];
  int          checks = 0;
  int          passed = 0;
  int          cyc = 0;
  int          last_due = 0;
  int          mem_lat = 1;
  logic [31:0] redir_target = 32'h0;
  bit          s_fire, s_pop, s_stall;
  logic [31:0] s_pc;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return (a * 32'h0019_660D) ^ 32'h1357_9BDF;
  endfunction

  // One clock of the environment: sample at negedge, then update inputs 1ns after posedge.
  task automatic step();
    ent_t  e;
    mreq_t m;
    int    due;
    @(negedge clk);
    s_fire  = imem_req_valid && imem_req_ready;
    s_pop   = dec_valid && dec_ready;
    s_stall = pc_stall;
    s_pc    = dec_pc;
    if (s_pop) begin
      checks++;
      if (exq.size() == 0) begin
        $display("FAIL dec_unexpected: got pc=%h instr=%h exc=%b, want no entry", dec_pc, dec_instr, dec_exc);
      end else begin
        e = exq.pop_front();
        if ({dec_pc, dec_instr, dec_exc} !== e)
          $display("FAIL dec_entry: got pc=%h instr=%h exc=%b, want pc=%h instr=%h exc=%b",
                   dec_pc, dec_instr, dec_exc, e.pc, e.instr, e.exc);
        else passed++;
      end
    end
    if (redirect) begin
      foreach (mq[i]) mq[i].stale = 1'b1;
      exq.delete();
    end
    if (imem_resp_valid && mq.size() > 0) begin
      m = mq.pop_front();
      if (!m.stale) exq.push_back({m.pc, mdata(m.addr), 1'b0});
    end
    if (s_fire) begin
      due = cyc + mem_lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq.push_back('{addr: {pc_in[31:2], 2'b00}, pc: pc_in, due: due, stale: 1'b0});
    end
    @(posedge clk);
    #1;
    cyc++;
    if (redirect) begin
      pc_in    = redir_target;
      redirect = 1'b0;
    end else if (s_fire) begin
      pc_in = pc_in + 32'd4;
    end
    imem_resp_valid = (mq.size() > 0) && (mq[0].due <= cyc);
    imem_resp_data  = imem_resp_valid ? mdata(mq[0].addr) : 32'h0;
  endtask

  task automatic do_reset(input logic [31:0] start);
    rst             = 1'b1;
    redirect        = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    pc_in           = start;
    mq.delete();
    exq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc++;
    last_due = cyc;
  endtask

  task automatic wait_pop(input int bound, output bit found);
    found = 1'b0;
    for (int i = 0; i < bound && !found; i++) begin
      step();
      if (s_pop) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b0; pc_in = 32'h0; dec_ready = 1'b1; imem_req_ready = 1'b1;
    imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    #2;
    checks++; if (dec_valid !== 1'b0) $display("FAIL rst_dec_valid: got %b want 0", dec_valid); else passed++;
    checks++; if (imem_req_valid !== 1'b0) $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); else passed++;
    checks++; if (pc_stall !== 1'b1) $display("FAIL rst_pc_stall: got %b want 1", pc_stall); else passed++;
    @(posedge clk); #1;
    checks++; if (imem_req_valid !== 1'b0) $display("FAIL rst_held_req_valid: got %b want 0", imem_req_valid); else passed++;
    rst = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b1) $display("FAIL rst_release_req_valid: got %b want 1", imem_req_valid); else passed++;
    checks++; if (imem_req_addr !== 32'h0) $display("FAIL rst_release_addr: got %h want 00000000", imem_req_addr); else passed++;
  endtask

  task automatic test_stream();
    int fires = 0, pops = 0, stalls = 0, first_pop = -1;
    do_reset(32'h0);
    mem_lat = 1; dec_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (s_fire) fires++;
      if (s_stall) stalls++;
      if (s_pop) begin
        if (first_pop < 0) begin
          first_pop = i;
          checks++; if (s_pc !== 32'h0) $display("FAIL stream_first_pc: got %h want 00000000", s_pc); else passed++;
        end
        pops++;
      end
    end
    checks++; if (fires != 12) $display("FAIL stream_fires: got %0d want 12", fires); else passed++;
    checks++; if (stalls != 0) $display("FAIL stream_stalls: got %0d want 0", stalls); else passed++;
    checks++; if (first_pop != 2) $display("FAIL stream_first_cycle: got %0d want 2", first_pop); else passed++;
    checks++; if (pops != 10) $display("FAIL stream_pops: got %0d want 10", pops); else passed++;
  endtask

  task automatic test_backpressure();
    int fires = 0, pops = 0;
    do_reset(32'h40);
    mem_lat = 1; dec_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (s_fire) fires++;
    end
    checks++; if (fires != 4) $display("FAIL bp_fires: got %0d want 4", fires); else passed++;
    checks++; if (s_stall !== 1'b1) $display("FAIL bp_pc_stall: got %b want 1", s_stall); else passed++;
    checks++; if (dec_valid !== 1'b1) $display("FAIL bp_dec_valid: got %b want 1", dec_valid); else passed++;
    dec_ready = 1'b1;
    for (int i = 0; i < 20 && pops < 4; i++) begin
      step();
      if (s_pop) begin
        if (pops == 0) begin
          checks++; if (s_pc !== 32'h40) $display("FAIL bp_first_pc: got %h want 00000040", s_pc); else passed++;
        end
        pops++;
      end
    end
    checks++; if (pops != 4) $display("FAIL bp_drained: got %0d want 4", pops); else passed++;
  endtask

  task automatic test_redirect_latency();
    bit found;
    int stale_cnt = 0;
    do_reset(32'h0);
    mem_lat = 3; dec_ready = 1'b1;
    step(); step();
    redirect = 1'b1; redir_target = 32'h100;
    step();
    checks++; if (s_fire) $display("FAIL redir_no_fire: got fire=1 want 0"); else passed++;
    foreach (mq[i]) if (mq[i].stale) stale_cnt++;
    checks++; if (dut.discard_q !== 3'(stale_cnt)) $display("FAIL redir_discard: got %0d want %0d", dut.discard_q, stale_cnt); else passed++;
    wait_pop(20, found);
    checks++;
    if (!found) $display("FAIL redir_pop_timeout: got no pop want pc 00000100");
    else if (s_pc !== 32'h100) $display("FAIL redir_first_pc: got %h want 00000100", s_pc);
    else passed++;
    mem_lat = 1;
  endtask

  task automatic test_redirect_same_cycle();
    bit found;
    int stale_cnt = 0;
    do_reset(32'h0);
    mem_lat = 2; dec_ready = 1'b1;
    step(); step();
    checks++; if (imem_resp_valid !== 1'b1 || mq.size() != 2) $display("FAIL same_setup: got resp=%b inflight=%0d want 1 and 2", imem_resp_valid, mq.size()); else passed++;
    redirect = 1'b1; redir_target = 32'h200;
    step();
    foreach (mq[i]) if (mq[i].stale) stale_cnt++;
    checks++; if (dut.discard_q !== 3'(stale_cnt)) $display("FAIL same_discard: got %0d want %0d", dut.discard_q, stale_cnt); else passed++;
    checks++; if (dut.outstanding_q !== 3'(mq.size())) $display("FAIL same_outstanding: got %0d want %0d", dut.outstanding_q, mq.size()); else passed++;
    wait_pop(20, found);
    checks++;
    if (!found) $display("FAIL same_pop_timeout: got no pop want pc 00000200");
    else if (s_pc !== 32'h200) $display("FAIL same_first_pc: got %h want 00000200", s_pc);
    else passed++;
    mem_lat = 1;
  endtask

  task automatic test_rst_mid();
    bit found;
    do_reset(32'h0);
    mem_lat = 1; dec_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checks++; if (dec_valid !== 1'b1) $display("FAIL rstmid_pre_valid: got %b want 1", dec_valid); else passed++;
    rst = 1'b1;
    #1;
    checks++; if (dec_valid !== 1'b0) $display("FAIL rstmid_dec_valid: got %b want 0", dec_valid); else passed++;
    checks++;
    if (dut.count_q !== 3'd0 || dut.outstanding_q !== 3'd0 || dut.discard_q !== 3'd0)
      $display("FAIL rstmid_counters: got count=%0d outstanding=%0d discard=%0d want 0 0 0",
               dut.count_q, dut.outstanding_q, dut.discard_q);
    else passed++;
    dec_ready = 1'b1;
    do_reset(32'h300);
    wait_pop(20, found);
    checks++;
    if (!found) $display("FAIL rstmid_pop_timeout: got no pop want pc 00000300");
    else if (s_pc !== 32'h300) $display("FAIL rstmid_first_pc: got %h want 00000300", s_pc);
    else passed++;
  endtask

`ifdef FETCH_MISALIGN_CHECK_EN
  task automatic test_misalign();
    bit found;
    int fires = 0, pops = 0;
    do_reset(32'h102);
    mem_lat = 1; dec_ready = 1'b1;
    exq.push_back({32'h102, 32'h0000_0013, 1'b1});
    for (int i = 0; i < 10; i++) begin
      step();
      if (s_fire) fires++;
      if (s_pop) pops++;
    end
    checks++; if (fires != 0) $display("FAIL mis_fires: got %0d want 0", fires); else passed++;
    checks++; if (pops != 1) $display("FAIL mis_pops: got %0d want 1", pops); else passed++;
    checks++; if (s_stall !== 1'b1) $display("FAIL mis_stall: got %b want 1", s_stall); else passed++;
    redirect = 1'b1; redir_target = 32'h110;
    step();
    wait_pop(20, found);
    checks++;
    if (!found) $display("FAIL mis_pop_timeout: got no pop want pc 00000110");
    else if (s_pc !== 32'h110) $display("FAIL mis_redir_pc: got %h want 00000110", s_pc);
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_latency();
    test_redirect_same_cycle();
    test_rst_mid();
`ifdef FETCH_MISALIGN_CHECK_EN
    test_misalign();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000ns want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Instruction-fetch stage directly downstream of the program counter. Each cycle it turns the current PC into an instruction-memory request and tracks outstanding requests. It buffers in-order responses, tagged with their PC, in a small FIFO and hands them to decode over a valid/ready handshake. It also drives a stall back to the PC stage and discards in-flight fetches when control flow is redirected.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of two, 2..16
- AW, 32, address/PC width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- pc_in  in  AW  current PC from the PC stage
- redirect  in  1  PC is loading a jump/branch target this cycle; flush everything younger
- pc_stall  out  1  PC must hold (control maps it to pc_op = 2'b11)
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  AW  request address (pc_in with [1:0] forced to 0)
- imem_resp_valid  in  1  in-order response strobe; always accepted
- imem_resp_data  in  32  instruction word
- dec_valid  out  1  queue head valid
- dec_ready  in  1  decode consumes head
- dec_instr  out  32  head instruction
- dec_pc  out  AW  head PC
- dec_exc  out  1  head carries misaligned-fetch exception (0 when feature is compiled out)

## Operation
- State: queue (DEPTH entries of {pc, instr, exc}), rd/wr pointers, `count` (0..DEPTH), `outstanding` (requests accepted, response not yet seen), `discard` (≤ outstanding: responses to drop), request-PC FIFO of depth DEPTH holding PCs of outstanding requests.
- Credit rule: imem_req_valid = !redirect && (count + outstanding < DEPTH). No queue overflow is possible; pushes are never refused.
- A request fires when imem_req_valid && imem_req_ready. Its pc_in is pushed to the request-PC FIFO and outstanding increments.
- pc_stall = !(request fires). The PC advances exactly once per fired request.
- Response arriving with discard > 0: dropped, discard and outstanding decrement, and the request-PC FIFO pops.
- Response arriving with discard = 0: {popped PC, data, 0} written to the queue and outstanding decrements.
- Pop: dec_valid && dec_ready, which decrements count. A push and a pop in the same cycle leave count unchanged and are legal at any fill level, including full.
- Redirect cycle:
  - queue emptied (count ← 0, pointers reset);
  - discard ← outstanding minus any response arriving this cycle; that response is itself dropped;
  - no request is issued.
- The first request for the new target issues the following cycle, if credit allows.
- dec_instr, dec_pc and dec_exc are driven from the head entry; their value is don't-care when dec_valid = 0.

## Timing
- Reset values: dec_valid 0, imem_req_valid 0, pc_stall 1, count/outstanding/discard 0, pointers 0. While rst is high, no request is issued.
- imem_req_valid, imem_req_addr and pc_stall are combinational from registered state, pc_in, redirect and imem_req_ready.
- Response to decode latency: a response accepted at edge N is visible as dec_valid = 1 after edge N, i.e. 1 cycle. There is no same-cycle bypass.
- Zero-wait memory (ready = 1, response one cycle after request) with decode always ready sustains 1 instruction per cycle.
- dec_ready low: the queue fills, credits run out, imem_req_valid falls and pc_stall rises. Nothing is lost.
- rst asserted mid-operation: all state clears immediately; any response arriving later is treated as fresh. The environment must also reset the memory.
- Pointers wrap modulo DEPTH. outstanding ≤ DEPTH is guaranteed by the credit rule.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined:
  - When pc_in[1:0] ≠ 0 and credit allows, no memory request is issued. Instead, an entry {pc_in, 32'h00000013, exc = 1} is pushed to the queue next cycle, ordered behind outstanding responses, and pc_stall stays high.
  - Afterwards, fetching stops: no further requests and no further synthetic entries until redirect.
- FETCH_MISALIGN_CHECK_EN undefined: pc_in[1:0] is ignored; imem_req_addr = {pc_in[AW-1:2], 2'b00}; dec_exc is tied to 0.

## Test plan
- Zero-wait memory, decode ready, PC 0x0 upward → dec_pc 0x0, 0x4, 0x8, … on consecutive cycles from cycle 2 onward; pc_stall low after the first fire.
- dec_ready held low for 10 cycles, DEPTH = 4 → exactly 4 requests fire, then pc_stall is high. On release, all 4 instructions drain in order with no loss and no duplication.
- Two requests outstanding, memory latency 3, redirect to 0x100 → both late responses are dropped; the next dec_pc is 0x100.
- Response arriving in the same cycle as redirect → it is dropped; discard equals the remaining outstanding count.
- rst pulsed while the queue holds 3 entries → dec_valid is 0 immediately, counters are 0; after release, fetch resumes from the new pc_in.
- FETCH_MISALIGN_CHECK_EN defined, pc_in = 0x102 → no memory request; entry dec_pc 0x102, dec_instr 0x00000013, dec_exc 1; fetch stays stopped until redirect.
